// File: rtl/sensor_poll_scheduler.sv
// sensor_poll_scheduler: autonomous poller for the SR04 and DHT11 controllers.
// Issues periodic start pulses, waits for each sensor's valid edge (or a timeout),
// then requests the matching UART reports. All pulse outputs are registered, 1 cycle wide.
// Optional feature macro: SENSOR_POLL_ERRCNT_EN adds per-sensor saturating timeout counters.
module sensor_poll_scheduler #(
    parameter int unsigned P_US_PER_MS       = 1000,
    parameter int unsigned P_SR04_PERIOD_MS  = 100,
    parameter int unsigned P_DHT11_PERIOD_MS = 2000,
    parameter int unsigned P_TIMEOUT_MS      = 50
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick1us,
    input  logic       iEnable,
    input  logic       iSr04DistanceValid,
    input  logic       iDhtDataValid,
    input  logic       iSenderBusy,
    output logic       oSr04Start,
    output logic       oDht11Start,
    output logic       oReqSr04Rpt,
    output logic       oReqTempRpt,
    output logic       oReqHumRpt,
    output logic       oBusy,
    output logic       oTimeout
`ifdef SENSOR_POLL_ERRCNT_EN
    ,
    output logic [7:0] oSr04ErrCnt,
    output logic [7:0] oDhtErrCnt
`endif
);

    localparam int unsigned UsW = (P_US_PER_MS > 1) ? $clog2(P_US_PER_MS) : 1;
    localparam int unsigned SrW = (P_SR04_PERIOD_MS > 1) ? $clog2(P_SR04_PERIOD_MS) : 1;
    localparam int unsigned DhW = (P_DHT11_PERIOD_MS > 1) ? $clog2(P_DHT11_PERIOD_MS) : 1;
    localparam int unsigned ToW = $clog2(P_TIMEOUT_MS + 1);

    localparam logic [UsW-1:0] UsLast = UsW'(P_US_PER_MS - 1);
    localparam logic [SrW-1:0] SrLast = SrW'(P_SR04_PERIOD_MS - 1);
    localparam logic [DhW-1:0] DhLast = DhW'(P_DHT11_PERIOD_MS - 1);
    localparam logic [ToW-1:0] ToMax  = ToW'(P_TIMEOUT_MS);

    typedef enum logic [3:0] {
        StIdle, StSr04St, StSr04Wait, StSr04Rpt,
        StDhtSt, StDhtWait, StDhtRptT, StDhtGap, StDhtRptH
    } stateE;

    stateE          stateQ, stateD;
    logic [UsW-1:0] usCntQ;
    logic [SrW-1:0] sr04CntQ;
    logic [DhW-1:0] dhtCntQ;
    logic [ToW-1:0] toCntQ;
    logic           msTick, sr04Expire, dhtExpire;
    logic           dueSr04Q, dueDhtQ;
    logic           sr04ValidQ, dhtValidQ, sr04Edge, dhtEdge;
    logic           inWait, toHit;
    logic           sr04StartD, dht11StartD, reqSr04D, reqTempD, reqHumD, timeoutD;

    // The whole time base freezes while polling is disabled.
    assign msTick     = iEnable & iTick1us & (usCntQ == UsLast);
    assign sr04Expire = msTick & (sr04CntQ == SrLast);
    assign dhtExpire  = msTick & (dhtCntQ == DhLast);
    assign sr04Edge   = iSr04DistanceValid & ~sr04ValidQ;
    assign dhtEdge    = iDhtDataValid & ~dhtValidQ;
    assign inWait     = (stateQ == StSr04Wait) || (stateQ == StDhtWait);
    assign toHit      = (toCntQ == ToMax);

    // Microsecond-to-millisecond prescaler.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            usCntQ <= '0;
        end else if (iEnable && iTick1us) begin
            usCntQ <= (usCntQ == UsLast) ? '0 : usCntQ + UsW'(1);
        end
    end

    // Per-sensor poll period counters.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            sr04CntQ <= '0;
            dhtCntQ  <= '0;
        end else if (msTick) begin
            sr04CntQ <= sr04Expire ? '0 : sr04CntQ + SrW'(1);
            dhtCntQ  <= dhtExpire ? '0 : dhtCntQ + DhW'(1);
        end
    end

    // Sticky due flags; a fresh expiry outranks consumption in the same cycle.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            dueSr04Q <= 1'b0;
            dueDhtQ  <= 1'b0;
        end else begin
            if (sr04Expire) begin
                dueSr04Q <= 1'b1;
            end else if (stateQ == StSr04St) begin
                dueSr04Q <= 1'b0;
            end
            if (dhtExpire) begin
                dueDhtQ <= 1'b1;
            end else if (stateQ == StDhtSt) begin
                dueDhtQ <= 1'b0;
            end
        end
    end

    // Previous-cycle copies of the valid flags for rising-edge detection.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            sr04ValidQ <= 1'b0;
            dhtValidQ  <= 1'b0;
        end else begin
            sr04ValidQ <= iSr04DistanceValid;
            dhtValidQ  <= iDhtDataValid;
        end
    end

    // Timeout counter: cleared on each start, counts ms ticks while waiting, saturates.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            toCntQ <= '0;
        end else if ((stateQ == StSr04St) || (stateQ == StDhtSt)) begin
            toCntQ <= '0;
        end else if (inWait && msTick && !toHit) begin
            toCntQ <= toCntQ + ToW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state and next pulse values; a report request that can go out at once skips the RPT
    // wait state so it lands on the cycle after the valid edge.
    always_comb begin
        stateD      = stateQ;
        sr04StartD  = 1'b0;
        dht11StartD = 1'b0;
        reqSr04D    = 1'b0;
        reqTempD    = 1'b0;
        reqHumD     = 1'b0;
        timeoutD    = oTimeout;
        unique case (stateQ)
            StIdle: begin
                if (iEnable && dueSr04Q) begin
                    stateD     = StSr04St;
                    sr04StartD = 1'b1;
                end else if (iEnable && dueDhtQ) begin
                    stateD      = StDhtSt;
                    dht11StartD = 1'b1;
                end
            end
            StSr04St: stateD = StSr04Wait;
            StSr04Wait: begin
                if (sr04Edge) begin
                    timeoutD = 1'b0;
                    if (!iSenderBusy) begin
                        reqSr04D = 1'b1;
                        stateD   = StIdle;
                    end else begin
                        stateD = StSr04Rpt;
                    end
                end else if (toHit) begin
                    timeoutD = 1'b1;
                    stateD   = StIdle;
                end
            end
            StSr04Rpt: begin
                if (!iSenderBusy) begin
                    reqSr04D = 1'b1;
                    stateD   = StIdle;
                end
            end
            StDhtSt: stateD = StDhtWait;
            StDhtWait: begin
                if (dhtEdge) begin
                    timeoutD = 1'b0;
                    if (!iSenderBusy) begin
                        reqTempD = 1'b1;
                        stateD   = StDhtGap;
                    end else begin
                        stateD = StDhtRptT;
                    end
                end else if (toHit) begin
                    timeoutD = 1'b1;
                    stateD   = StIdle;
                end
            end
            StDhtRptT: begin
                if (!iSenderBusy) begin
                    reqTempD = 1'b1;
                    stateD   = StDhtGap;
                end
            end
            // Gives the sender a cycle to raise busy after the temperature request.
            StDhtGap: stateD = StDhtRptH;
            StDhtRptH: begin
                if (!iSenderBusy) begin
                    reqHumD = 1'b1;
                    stateD  = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oSr04Start  <= 1'b0;
            oDht11Start <= 1'b0;
            oReqSr04Rpt <= 1'b0;
            oReqTempRpt <= 1'b0;
            oReqHumRpt  <= 1'b0;
            oBusy       <= 1'b0;
            oTimeout    <= 1'b0;
        end else begin
            oSr04Start  <= sr04StartD;
            oDht11Start <= dht11StartD;
            oReqSr04Rpt <= reqSr04D;
            oReqTempRpt <= reqTempD;
            oReqHumRpt  <= reqHumD;
            oBusy       <= (stateD != StIdle);
            oTimeout    <= timeoutD;
        end
    end

`ifdef SENSOR_POLL_ERRCNT_EN
    logic sr04TimeoutEv, dhtTimeoutEv;

    assign sr04TimeoutEv = (stateQ == StSr04Wait) & ~sr04Edge & toHit;
    assign dhtTimeoutEv  = (stateQ == StDhtWait) & ~dhtEdge & toHit;

    // Saturating per-sensor timeout counters, cleared only by reset.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oSr04ErrCnt <= '0;
            oDhtErrCnt  <= '0;
        end else begin
            if (sr04TimeoutEv && (oSr04ErrCnt != 8'hFF)) begin
                oSr04ErrCnt <= oSr04ErrCnt + 8'd1;
            end
            if (dhtTimeoutEv && (oDhtErrCnt != 8'hFF)) begin
                oDhtErrCnt <= oDhtErrCnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed self-checking bench for sensor_poll_scheduler with a small time base
// (10 ticks/ms, SR04 every 3 ms, DHT11 every 7 ms, 4 ms timeout, tick every cycle).
module tb_sensor_poll_scheduler;

    logic iClk, iRst, iTick1us, iEnable;
    logic iSr04DistanceValid, iDhtDataValid, iSenderBusy;
    logic oSr04Start, oDht11Start, oReqSr04Rpt, oReqTempRpt, oReqHumRpt, oBusy, oTimeout;
`ifdef SENSOR_POLL_ERRCNT_EN
    logic [7:0] sr04ErrCnt, dhtErrCnt;
`endif

    sensor_poll_scheduler #(
        .P_US_PER_MS      (10),
        .P_SR04_PERIOD_MS (3),
        .P_DHT11_PERIOD_MS(7),
        .P_TIMEOUT_MS     (4)
    ) dut (
        .iClk              (iClk),
        .iRst              (iRst),
        .iTick1us          (iTick1us),
        .iEnable           (iEnable),
        .iSr04DistanceValid(iSr04DistanceValid),
        .iDhtDataValid     (iDhtDataValid),
        .iSenderBusy       (iSenderBusy),
        .oSr04Start        (oSr04Start),
        .oDht11Start       (oDht11Start),
        .oReqSr04Rpt       (oReqSr04Rpt),
        .oReqTempRpt       (oReqTempRpt),
        .oReqHumRpt        (oReqHumRpt),
        .oBusy             (oBusy),
        .oTimeout          (oTimeout)
`ifdef SENSOR_POLL_ERRCNT_EN
        ,
        .oSr04ErrCnt       (sr04ErrCnt),
        .oDhtErrCnt        (dhtErrCnt)
`endif
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int cyc, nChecks, nPass, nFail, multiPulse, widthViol, snap;
    int nSr04Start, nDhtStart, nReqSr04, nReqTemp, nReqHum;
    int lastSr04StartCyc, lastDhtStartCyc, lastReqSr04Cyc, lastReqHumCyc;
    logic [4:0] prevPulse, curPulse;
    bit autoServe, srArm, dhArm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge, track pulses, optionally answer start pulses.
    task automatic step();
        @(posedge iClk);
        #1;
        cyc++;
        curPulse = {oSr04Start, oDht11Start, oReqSr04Rpt, oReqTempRpt, oReqHumRpt};
        if ($countones(curPulse) > 1) multiPulse++;
        if ((curPulse & prevPulse) != 5'b0) widthViol++;
        prevPulse = curPulse;
        if (oSr04Start)  begin nSr04Start++; lastSr04StartCyc = cyc; end
        if (oDht11Start) begin nDhtStart++;  lastDhtStartCyc  = cyc; end
        if (oReqSr04Rpt) begin nReqSr04++;   lastReqSr04Cyc   = cyc; end
        if (oReqTempRpt) nReqTemp++;
        if (oReqHumRpt)  begin nReqHum++;    lastReqHumCyc    = cyc; end
        if (autoServe) begin
            if (iSr04DistanceValid) iSr04DistanceValid = 1'b0;
            else if (srArm) begin iSr04DistanceValid = 1'b1; srArm = 1'b0; end
            if (iDhtDataValid) iDhtDataValid = 1'b0;
            else if (dhArm) begin iDhtDataValid = 1'b1; dhArm = 1'b0; end
            if (oSr04Start)  srArm = 1'b1;
            if (oDht11Start) dhArm = 1'b1;
        end
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        iRst = 1'b0; iTick1us = 1'b1; iEnable = 1'b0;
        iSr04DistanceValid = 1'b0; iDhtDataValid = 1'b0; iSenderBusy = 1'b0;
        cyc = 0; nChecks = 0; nPass = 0; nFail = 0; multiPulse = 0; widthViol = 0;
        nSr04Start = 0; nDhtStart = 0; nReqSr04 = 0; nReqTemp = 0; nReqHum = 0;
        lastSr04StartCyc = -1; lastDhtStartCyc = -1; lastReqSr04Cyc = -1; lastReqHumCyc = -1;
        prevPulse = '0; curPulse = '0; autoServe = 0; srArm = 0; dhArm = 0; snap = 0;

        repeat (3) step();
        check("rst_sr04Start", oSr04Start, 0);
        check("rst_dht11Start", oDht11Start, 0);
        check("rst_reqSr04", oReqSr04Rpt, 0);
        check("rst_reqTemp", oReqTempRpt, 0);
        check("rst_reqHum", oReqHumRpt, 0);
        check("rst_busy", oBusy, 0);
        check("rst_timeout", oTimeout, 0);

        // SR04 due at 3rd ms tick (edge 30) -> start visible at cycle 31, no sensor answer.
        iRst = 1'b1; iEnable = 1'b1; cyc = 0;
        stepTo(30);
        check("no_early_start", nSr04Start, 0);
        stepTo(31);
        check("first_sr04_start", oSr04Start, 1);
        check("busy_after_start", oBusy, 1);
        stepTo(70);
        check("timeout_not_yet", oTimeout, 0);
        check("busy_in_wait", oBusy, 1);
        stepTo(71);
        check("timeout_set", oTimeout, 1);
        check("idle_after_timeout", oBusy, 0);
        check("no_rpt_on_timeout", nReqSr04, 0);
`ifdef SENSOR_POLL_ERRCNT_EN
        check("sr04_errcnt_one", sr04ErrCnt, 1);
        check("dht_errcnt_zero", dhtErrCnt, 0);
`endif
        // Both SR04 and DHT pending now: SR04 goes first.
        stepTo(72);
        check("pending_sr04_first", oSr04Start, 1);
        check("pending_dht_held", oDht11Start, 0);
        // Nominal SR04: valid edge 5 cycles after start, report the cycle after.
        stepTo(77);
        iSr04DistanceValid = 1'b1;
        stepTo(78);
        check("sr04_rpt", oReqSr04Rpt, 1);
        check("timeout_cleared", oTimeout, 0);
        stepTo(79);
        check("sr04_rpt_once", nReqSr04, 1);
        check("dht_start_after_sr04", oDht11Start, 1);
        iSr04DistanceValid = 1'b0;

        // DHT frame with the sender busy for 20 cycles.
        stepTo(80);
        iDhtDataValid = 1'b1; iSenderBusy = 1'b1;
        stepTo(100);
        check("temp_held_by_busy", nReqTemp, 0);
        check("busy_in_rpt", oBusy, 1);
        iSenderBusy = 1'b0;
        stepTo(101);
        check("temp_rpt", oReqTempRpt, 1);
        check("dht_timeout_clear", oTimeout, 0);
        iSenderBusy = 1'b1; iDhtDataValid = 1'b0;
        stepTo(106);
        check("hum_held_by_busy", nReqHum, 0);
        iSenderBusy = 1'b0;
        stepTo(107);
        check("hum_rpt", oReqHumRpt, 1);
        check("temp_once", nReqTemp, 1);
        stepTo(108);
        check("sr04_after_dht", oSr04Start, 1);

        // Reset while in SR04 wait.
        stepTo(110);
        check("busy_before_reset", oBusy, 1);
        #1 iRst = 1'b0;
        #1;
        check("midrst_busy", oBusy, 0);
        check("midrst_sr04Start", oSr04Start, 0);
        check("midrst_dht11Start", oDht11Start, 0);
        check("midrst_reqs", {oReqSr04Rpt, oReqTempRpt, oReqHumRpt}, 0);
        check("midrst_timeout", oTimeout, 0);
        step(); step();
        snap = nReqSr04;
        iRst = 1'b1; iEnable = 1'b1; iSr04DistanceValid = 1'b1; cyc = 0;
        stepTo(20);
        check("no_rpt_after_reset", nReqSr04 - snap, 0);
        check("idle_after_reset", oBusy, 0);
`ifdef SENSOR_POLL_ERRCNT_EN
        check("errcnt_reset", sr04ErrCnt, 0);
`endif
        iSr04DistanceValid = 1'b0;

        // Disable for 50 ms worth of ticks with the period counters mid-way.
        stepTo(25);
        iEnable = 1'b0;
        snap = nSr04Start + nDhtStart;
        stepTo(525);
        check("no_start_disabled", nSr04Start + nDhtStart - snap, 0);
        check("idle_disabled", oBusy, 0);
        iEnable = 1'b1; autoServe = 1;
        stepTo(530);
        check("resume_no_early", nSr04Start + nDhtStart - snap, 0);
        stepTo(531);
        check("resume_start", oSr04Start, 1);

        // 21st ms tick (edge 710) expires both periods together.
        stepTo(711);
        check("same_tick_sr04_first", oSr04Start, 1);
        check("same_tick_dht_wait", oDht11Start, 0);
        check("prev_dht_start", lastDhtStartCyc, 641);
        stepTo(714);
        check("same_tick_sr04_rpt", lastReqSr04Cyc, 713);
        check("same_tick_dht_next", oDht11Start, 1);
        stepTo(720);
        check("auto_hum_rpt", lastReqHumCyc, 718);
        check("no_timeout_auto", oTimeout, 0);

        check("one_pulse_per_cycle", multiPulse, 0);
        check("pulse_width_one", widthViol, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
